// File: rtl/dram_responder_if.sv
// rtl/dram_responder_if.sv - MEM-stage data bus between the pipeline and the data-memory responder
interface dram_responder_if;
  logic        ce_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [3:0]  sel_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        ack_o;
  logic        stall_req_o;

  // MEM stage drives the request and sees the response
  modport master (
    output ce_i, we_i, addr_i, sel_i, wdata_i,
    input  rdata_o, ack_o, stall_req_o
  );

  // Responder consumes the request and drives the response
  modport slave (
    input  ce_i, we_i, addr_i, sel_i, wdata_i,
    output rdata_o, ack_o, stall_req_o
  );
endinterface

// File: rtl/dram_responder.sv
// rtl/dram_responder.sv - wait-stated, big-endian, byte-writable data RAM responder with stall request
module dram_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 1
) (
  input logic              clk,
  input logic              rst,
  dram_responder_if.slave  bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] WCNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                  state_q;
  logic [3:0]              wcnt_q;
  logic                    req_we_q;
  logic [3:0]              req_sel_q;
  logic [DEPTH_LOG2-1:0]   req_idx_q;
  logic [31:0]             req_wdata_q;
  logic [31:0]             rdata_q;
  logic                    ack_q;

  logic [31:0]             mem [DEPTH];

  logic [DEPTH_LOG2-1:0]   in_idx;
  logic                    go_done;
  logic                    acc_we;
  logic [3:0]              acc_sel;
  logic [DEPTH_LOG2-1:0]   acc_idx;
  logic [31:0]             acc_wdata;
  logic                    unused_addr_bits;

  assign in_idx           = bus.addr_i[DEPTH_LOG2+1:2];
  assign unused_addr_bits = ^{bus.addr_i[31:DEPTH_LOG2+2], bus.addr_i[1:0]};

  // Pick the request that completes this edge: live inputs for a zero-wait accept, captured copy otherwise
  always_comb begin
    go_done   = 1'b0;
    acc_we    = req_we_q;
    acc_sel   = req_sel_q;
    acc_idx   = req_idx_q;
    acc_wdata = req_wdata_q;
    if (state_q == S_IDLE) begin
      acc_we    = bus.we_i;
      acc_sel   = bus.sel_i;
      acc_idx   = in_idx;
      acc_wdata = bus.wdata_i;
      go_done   = bus.ce_i && (WAIT_STATES == 0);
    end else if (state_q == S_ACCESS) begin
      go_done   = bus.ce_i && (wcnt_q == 4'd0);
    end
  end

  // Access sequencing, request capture and registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wcnt_q      <= 4'd0;
      req_we_q    <= 1'b0;
      req_sel_q   <= 4'd0;
      req_idx_q   <= '0;
      req_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
      ack_q       <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.ce_i) begin
            req_we_q    <= bus.we_i;
            req_sel_q   <= bus.sel_i;
            req_idx_q   <= in_idx;
            req_wdata_q <= bus.wdata_i;
            if (WAIT_STATES == 0) begin
              state_q <= S_DONE;
            end else begin
              state_q <= S_ACCESS;
              wcnt_q  <= WCNT_INIT;
            end
          end
        end
        S_ACCESS: begin
          if (!bus.ce_i) begin
            state_q <= S_IDLE;
          end else if (wcnt_q == 4'd0) begin
            state_q <= S_DONE;
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      if (go_done) begin
        ack_q <= 1'b1;
        if (!acc_we) rdata_q <= mem[acc_idx];
      end
    end
  end

  // Byte-lane RAM write on the edge that enters DONE; reset cancels it
  always_ff @(posedge clk) begin
    if (!rst && go_done && acc_we) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_sel[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  assign bus.rdata_o     = rdata_q;
  assign bus.ack_o       = ack_q;
  assign bus.stall_req_o = bus.ce_i && (state_q != S_DONE);

endmodule

// File: tb/tb_dram_responder.sv
// tb/tb_dram_responder.sv - randomized and directed bench for dram_responder against a word-array model
module tb_dram_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        ce    [3];
  logic        we    [3];
  logic [31:0] addr  [3];
  logic [3:0]  sel   [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        ack   [3];
  logic        stall [3];

  int ws_of [3] = '{2, 3, 0};
  int dl_of [3] = '{4, 10, 10};

  logic [31:0] mm [3][1024];
  logic [31:0] last_rd [3];

  int n_cmp = 0;
  int n_err = 0;

  dram_responder_if bus0 ();
  dram_responder_if bus1 ();
  dram_responder_if bus2 ();

  assign bus0.ce_i = ce[0]; assign bus0.we_i = we[0]; assign bus0.addr_i = addr[0];
  assign bus0.sel_i = sel[0]; assign bus0.wdata_i = wdata[0];
  assign rdata[0] = bus0.rdata_o; assign ack[0] = bus0.ack_o; assign stall[0] = bus0.stall_req_o;
  assign bus1.ce_i = ce[1]; assign bus1.we_i = we[1]; assign bus1.addr_i = addr[1];
  assign bus1.sel_i = sel[1]; assign bus1.wdata_i = wdata[1];
  assign rdata[1] = bus1.rdata_o; assign ack[1] = bus1.ack_o; assign stall[1] = bus1.stall_req_o;
  assign bus2.ce_i = ce[2]; assign bus2.we_i = we[2]; assign bus2.addr_i = addr[2];
  assign bus2.sel_i = sel[2]; assign bus2.wdata_i = wdata[2];
  assign rdata[2] = bus2.rdata_o; assign ack[2] = bus2.ack_o; assign stall[2] = bus2.stall_req_o;

  dram_responder #(.DEPTH_LOG2(4),  .WAIT_STATES(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  dram_responder #(.DEPTH_LOG2(10), .WAIT_STATES(3)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  dram_responder #(.DEPTH_LOG2(10), .WAIT_STATES(0)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input int k, input logic [31:0] a);
    return int'((a >> 2) & ((32'd1 << dl_of[k]) - 32'd1));
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w = old;
    for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    return w;
  endfunction

  // One complete access with ce held until ack; checks latency, stall duration and read data
  task automatic do_access(input string tag, input int k, input logic wv, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] d);
    int n = 0;
    int nst = 0;
    int ix = widx(k, a);
    @(negedge clk);
    ce[k] = 1'b1; we[k] = wv; addr[k] = a; sel[k] = s; wdata[k] = d;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (ack[k]) break;
      if (stall[k]) nst++;
      n++;
      @(negedge clk);
    end
    if (wv) mm[k][ix] = merge(mm[k][ix], d, s);
    else    last_rd[k] = mm[k][ix];
    chk({tag, ".latency"}, 32'(n), 32'(ws_of[k] + 1));
    chk({tag, ".stall_cycles"}, 32'(nst), 32'(ws_of[k] + 1));
    chk({tag, ".stall_in_done"}, {31'd0, stall[k]}, 32'd0);
    chk({tag, ".rdata"}, rdata[k], last_rd[k]);
    ce[k] = 1'b0;
  endtask

  // Continuous reads with ce never dropped; checks ack spacing and data
  task automatic b2b_read(input string tag, input int k, input logic [31:0] a, input int nacks);
    int prev = 0;
    int cnt = 0;
    logic [31:0] exp = mm[k][widx(k, a)];
    @(negedge clk);
    ce[k] = 1'b1; we[k] = 1'b0; addr[k] = a; sel[k] = 4'hF;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (ack[k]) begin
        if (cnt == 0) chk({tag, ".first_latency"}, 32'(c), 32'(ws_of[k] + 1));
        else          chk({tag, ".ack_gap"}, 32'(c - prev), 32'(ws_of[k] + 2));
        chk({tag, ".rdata"}, rdata[k], exp);
        prev = c;
        cnt++;
        if (cnt == nacks) break;
      end
      @(negedge clk);
    end
    chk({tag, ".ack_count"}, 32'(cnt), 32'(nacks));
    last_rd[k] = exp;
    ce[k] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      ce[k] = 1'b0; we[k] = 1'b0; addr[k] = 32'd0; sel[k] = 4'd0; wdata[k] = 32'd0;
      last_rd[k] = 32'd0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset.ack", {31'd0, ack[k]}, 32'd0);
      chk("reset.rdata", rdata[k], 32'd0);
      chk("reset.stall", {31'd0, stall[k]}, 32'd0);
    end

    // Read latency with WAIT_STATES=2
    do_access("pre_w3", 0, 1'b1, 32'h0000_000C, 4'hF, 32'h1122_3344);
    do_access("rd_w3", 0, 1'b0, 32'h0000_000C, 4'hF, 32'h0);
    chk("rd_w3.literal", rdata[0], 32'h1122_3344);

    // Byte-lane writes, big-endian lanes
    do_access("pre_w1", 0, 1'b1, 32'h0000_0004, 4'hF, 32'h1122_3344);
    do_access("bw_0100", 0, 1'b1, 32'h0000_0005, 4'b0100, 32'hAAAA_AAAA);
    do_access("rd_bw1", 0, 1'b0, 32'h0000_0004, 4'hF, 32'h0);
    chk("rd_bw1.literal", rdata[0], 32'h11AA_3344);
    do_access("bw_0011", 0, 1'b1, 32'h0000_0004, 4'b0011, 32'h5555_5555);
    do_access("bw_0000", 0, 1'b1, 32'h0000_0004, 4'b0000, 32'h9999_9999);
    do_access("rd_bw2", 0, 1'b0, 32'h0000_0004, 4'hF, 32'h0);
    chk("rd_bw2.literal", rdata[0], 32'h11AA_5555);

    // Abort in the second ACCESS cycle, WAIT_STATES=3
    do_access("pre_w2", 1, 1'b1, 32'h0000_0008, 4'hF, 32'hCAFE_F00D);
    @(negedge clk);
    ce[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h0000_0008; sel[1] = 4'hF; wdata[1] = 32'hDEAD_BEEF;
    @(negedge clk);
    @(negedge clk);
    ce[1] = 1'b0;
    #1;
    chk("abort.stall", {31'd0, stall[1]}, 32'd0);
    chk("abort.ack", {31'd0, ack[1]}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      chk("abort.no_ack", {31'd0, ack[1]}, 32'd0);
    end
    do_access("abort_rd", 1, 1'b0, 32'h0000_0008, 4'hF, 32'h0);
    chk("abort_rd.literal", rdata[1], 32'hCAFE_F00D);

    // Reset during the ACCESS cycle of a write
    @(negedge clk);
    ce[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h0000_0004; sel[0] = 4'hF; wdata[0] = 32'h0BAD_0BAD;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; ce[0] = 1'b0;
    for (int k = 0; k < 3; k++) last_rd[k] = 32'd0;
    #1;
    chk("rst_mid.ack", {31'd0, ack[0]}, 32'd0);
    chk("rst_mid.rdata", rdata[0], 32'd0);
    chk("rst_mid.stall", {31'd0, stall[0]}, 32'd0);
    do_access("rst_mid_rd", 0, 1'b0, 32'h0000_0004, 4'hF, 32'h0);

    // Aliasing at depth 16 and back-to-back reads with ce held
    do_access("alias_w", 0, 1'b1, 32'h0000_0040, 4'hF, 32'h1234_5678);
    b2b_read("b2b", 0, 32'h0000_0000, 3);
    chk("b2b.literal", rdata[0], 32'h1234_5678);

    // Zero wait states
    do_access("ws0_w", 2, 1'b1, 32'h0000_0010, 4'hF, 32'hA5A5_5A5A);
    do_access("ws0_r", 2, 1'b0, 32'h0000_0010, 4'hF, 32'h0);
    b2b_read("ws0_b2b", 2, 32'h0000_0010, 3);

    // Randomized traffic against the model
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++)
        do_access("rnd_pre", k, 1'b1, 32'(i) << 2, 4'hF, $urandom);
      for (int i = 0; i < 25; i++) begin
        logic [31:0] a;
        a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        if (k == 0) a = a | ($urandom & 32'hFFFF_FFC0);
        do_access("rnd", k, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
